cda_sum_unit: RTL and testbench

Parametrised, registered arithmetic unit that generalises the team's single-cycle combinational `a + b + 1` adder. It adds configurable width, a per-sample mode (wrapping add, saturating add, accumulate, moving average) and a valid-qualified one-cycle pipeline. It sits behind the chip's dedicated input pins and drives the dedicated outputs in the next demo top level.

---
 rtl/cda_sum_pkg.sv | 16 +
 rtl/cda_sum_unit_if.sv | 23 ++
 rtl/cda_window_buf.sv | 53 +++++
 rtl/cda_sum_unit.sv | 91 +++++++++
 tb/tb_cda_sum_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cda_sum_pkg.sv
// Shared types and width helpers for the cda_sum_unit arithmetic block.
package cda_sum_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SAT = 2'd1,
        MODE_ACC = 2'd2,
        MODE_WIN = 2'd3
    } cda_mode_e;

    // Running-sum width for a DEPTH-entry window of WIDTH-bit samples.
    function automatic int unsigned rsum_width(input int unsigned width, input int unsigned depth);
        return width + $clog2(depth);
    endfunction

endpackage

// File: rtl/cda_sum_unit_if.sv
// Sample/result bus of cda_sum_unit; master drives samples, slave returns results.
interface cda_sum_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       mode;
    logic             clr;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, mode, clr,
        input  out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, mode, clr,
        output out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/cda_window_buf.sv
// Moving-average window: circular sample buffer, write pointer and running sum.
module cda_window_buf
    import cda_sum_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] avg
);
    localparam int unsigned LOG2 = $clog2(DEPTH);
    localparam int unsigned RW   = rsum_width(WIDTH, DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [LOG2-1:0]  wptr_q, wptr_d;
    logic [RW-1:0]    rsum_q, rsum_d, rsum_new;

    always_comb begin
        // Intermediate may underflow; the final value is exact modulo 2^RW.
        rsum_new = rsum_q - RW'(mem_q[wptr_q]) + RW'(din);
        avg      = rsum_new[RW-1:LOG2];
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rsum_d   = rsum_q;
        if (clr) begin
            mem_d  = '{default: '0};
            wptr_d = '0;
            rsum_d = '0;
        end else if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + LOG2'(1);
            rsum_d        = rsum_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rsum_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rsum_q <= rsum_d;
        end
    end

endmodule

// File: rtl/cda_sum_unit.sv
// Registered multi-mode adder: wrapping/saturating add, accumulate, moving average.
module cda_sum_unit
    import cda_sum_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned INC   = 1
) (
    input logic           clk,
    input logic           rst_n,
    cda_sum_unit_if.slave bus
);
    localparam logic [WIDTH:0] INC_EXT = (WIDTH+1)'(INC);

    cda_mode_e        mode;
    logic             accept, win_push;
    logic [WIDTH:0]   sum_full, acc_full;
    logic [WIDTH-1:0] win_avg;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    cda_window_buf #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_win (
        .clk  (clk),
        .rst_n(rst_n),
        .push (win_push),
        .clr  (bus.clr),
        .din  (bus.in_a),
        .avg  (win_avg)
    );

    always_comb begin
        mode        = cda_mode_e'(bus.mode);
        // A clear in the same cycle drops the sample entirely.
        accept      = bus.in_valid & ~bus.clr;
        win_push    = accept && (mode == MODE_WIN);
        sum_full    = {1'b0, bus.in_a} + {1'b0, bus.in_b} + INC_EXT;
        acc_full    = {1'b0, acc_q} + {1'b0, bus.in_a};
        acc_d       = acc_q;
        out_valid_d = accept;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (bus.clr) begin
            acc_d = '0;
        end
        if (accept) begin
            case (mode)
                MODE_ADD: begin
                    out_data_d = sum_full[WIDTH-1:0];
                    out_ovf_d  = sum_full[WIDTH];
                end
                MODE_SAT: begin
                    out_data_d = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
                    out_ovf_d  = sum_full[WIDTH];
                end
                MODE_ACC: begin
                    acc_d      = acc_full[WIDTH-1:0];
                    out_data_d = acc_full[WIDTH-1:0];
                    out_ovf_d  = acc_full[WIDTH];
                end
                MODE_WIN: begin
                    out_data_d = win_avg;
                    out_ovf_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cda_sum_unit.sv
// Scoreboard bench for cda_sum_unit (WIDTH=8, DEPTH=4, INC=1) with a queue-based reference model.
module tb_cda_sum_unit;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        int         due;
    } exp_t;

    logic clk;
    logic rst_n;
    bit   done;
    int   neg_cnt;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    // Reference model state
    int acc_m;
    int win_m[$];

    cda_sum_unit_if #(.WIDTH(8)) bus ();

    cda_sum_unit #(
        .WIDTH(8),
        .DEPTH(4),
        .INC  (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        acc_m = 0;
        win_m = '{0, 0, 0, 0};
    endtask

    task automatic issue(input bit v, input int m, input int a, input int b, input bit c);
        int   s;
        int   d;
        bit   o;
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.mode     = m[1:0];
        bus.in_a     = a[7:0];
        bus.in_b     = b[7:0];
        bus.clr      = c;
        d = 0;
        o = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            case (m)
                0: begin
                    s = a + b + 1;
                    d = s % 256;
                    o = (s > 255);
                end
                1: begin
                    s = a + b + 1;
                    d = (s > 255) ? 255 : s;
                    o = (s > 255);
                end
                2: begin
                    s = acc_m + a;
                    o = (s > 255);
                    acc_m = s % 256;
                    d = acc_m;
                end
                default: begin
                    void'(win_m.pop_front());
                    win_m.push_back(a);
                    s = 0;
                    foreach (win_m[i]) s += win_m[i];
                    d = s / 4;
                    o = 1'b0;
                end
            endcase
            e.data = d[7:0];
            e.ovf  = o;
            e.due  = neg_cnt + 2;
            exp_q.push_back(e);
        end
    endtask

    // Stimulus
    initial begin
        int m;
        done         = 1'b0;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode     = 2'd0;
        bus.in_a     = 8'd0;
        bus.in_b     = 8'd0;
        bus.clr      = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        issue(1, 0, 'h10, 'h20, 0);
        issue(1, 0, 'hFF, 'h00, 0);
        issue(1, 1, 'hF0, 'h20, 0);
        issue(1, 1, 'h7E, 'h80, 0);
        issue(1, 2, 'h80, 0, 0);
        issue(1, 2, 'h80, 0, 0);
        issue(1, 2, 'h80, 0, 0);
        issue(0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) issue(1, 3, 4 * k, 0, 0);
        issue(0, 0, 0, 0, 1);
        issue(1, 2, 5, 0, 0);
        issue(1, 3, 8, 0, 0);
        issue(1, 2, 5, 0, 0);
        issue(1, 2, 7, 0, 1);
        issue(1, 2, 1, 0, 0);

        // Asynchronous reset while a WIN sample is waiting to be accepted
        issue(1, 2, 3, 0, 0);
        issue(1, 3, 8, 0, 0);
        #6;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        issue(1, 3, 8, 0, 0);

        for (int k = 0; k < 400; k++) begin
            m = int'($urandom_range(0, 3));
            issue(($urandom % 4) != 0, m, int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), ($urandom % 16) == 0);
        end
        repeat (3) issue(0, 0, 0, 0, 0);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        bit         prev_rst;
        bit         bad;
        exp_t       e;
        logic [7:0] last_d;
        logic       last_o;
        prev_rst = 1'b1;
        neg_cnt  = 0;
        n_vec    = 0;
        n_err    = 0;
        last_d   = 8'd0;
        last_o   = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (prev_rst && !rst_n) begin
                #1;
                n_vec++;
                if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_ovf !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_state: got valid=%b data=%02h ovf=%b, expected 0/00/0",
                             bus.out_valid, bus.out_data, bus.out_ovf);
                end
                exp_q.delete();
                last_d = 8'd0;
                last_o = 1'b0;
            end else if (!clk) begin
                neg_cnt++;
                if (!rst_n) begin
                    exp_q.delete();
                    last_d = 8'd0;
                    last_o = 1'b0;
                end else if (bus.out_valid === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_valid: got data=%02h ovf=%b, expected no output",
                                 bus.out_data, bus.out_ovf);
                    end else begin
                        e   = exp_q.pop_front();
                        bad = (bus.out_data !== e.data) || (bus.out_ovf !== e.ovf) || (e.due != neg_cnt);
                        if (bad) begin
                            n_err++;
                            $display("FAIL result: got data=%02h ovf=%b at cycle %0d, expected data=%02h ovf=%b at cycle %0d",
                                     bus.out_data, bus.out_ovf, neg_cnt, e.data, e.ovf, e.due);
                        end
                    end
                    last_d = bus.out_data;
                    last_o = bus.out_ovf;
                end else begin
                    n_vec++;
                    if (bus.out_valid !== 1'b0 || bus.out_data !== last_d || bus.out_ovf !== last_o) begin
                        n_err++;
                        $display("FAIL hold: got valid=%b data=%02h ovf=%b, expected valid=0 data=%02h ovf=%b",
                                 bus.out_valid, bus.out_data, bus.out_ovf, last_d, last_o);
                    end
                    if (exp_q.size() != 0 && exp_q[0].due <= neg_cnt) begin
                        e = exp_q.pop_front();
                        n_vec++;
                        n_err++;
                        $display("FAIL missing_valid: got no output at cycle %0d, expected data=%02h ovf=%b",
                                 neg_cnt, e.data, e.ovf);
                    end
                end
                if (done) begin
                    n_vec++;
                    if (exp_q.size() != 0) begin
                        n_err++;
                        $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
                    end
                    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                    $finish;
                end
            end
            prev_rst = rst_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected completion within time limit");
        $fatal(1, "timeout");
    end

endmodule
